riscv_mem_access_unit: RTL
==========================

# riscv_mem_access_unit

Initiator-side load/store unit that drives the word-organized synchronous RISC-V memory port (read_en / write_en / address / write_data / read_data, one-cycle read latency, word-aligned, ignores address[1:0]). Accepts one byte, halfword or word load/store request at a time from the pipeline. Performs sub-word extraction with sign/zero extension on loads and read-modify-write merging on sub-word stores. Reports misaligned or illegal accesses without touching memory.

## Interface
Parameters:
- PRINT_MEMORY_TRANSACTIONS, 0, when 1, simulation-only $display of each accepted request and each response

Ports:
- clk  input  1  system clock; all state changes on posedge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present; sampled only when req_ready=1
- req_ready  output  1  1 only in IDLE
- req_write  input  1  1=store, 0=load
- req_funct3  input  3  RISC-V funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
- req_address  input  32  byte address
- req_wdata  input  32  store data; low byte/halfword used for SB/SH
- resp_valid  output  1  one-cycle pulse: request complete
- resp_error  output  1  valid with resp_valid; misaligned or illegal funct3
- resp_rdata  output  32  load result, valid with resp_valid; 0 for stores and errors
- mem_read_en  output  1  to memory read_en
- mem_write_en  output  1  to memory write_en
- mem_address  output  32  {addr_q[31:2], 2'b00}
- mem_write_data  output  32  word to write
- mem_read_data  input  32  memory read_data, valid the cycle after mem_read_en

## Operation
- Accept: req_valid && req_ready at posedge N; register write, funct3, address, wdata; decode into next state.
- States: IDLE, READ, LOAD_RESP, STORE_WORD, MERGE_WRITE, ERROR_RESP.
- IDLE -> ERROR_RESP: misaligned (halfword addr[0]=1; word addr[1:0]!=00) or illegal funct3 (load 011/110/111; store >010).
- IDLE -> READ: any legal load, SB, SH.
- IDLE -> STORE_WORD: legal SW.
- READ: mem_read_en=1, mem_address driven; -> LOAD_RESP (load) or MERGE_WRITE (SB/SH).
- LOAD_RESP: select lane by addr_q[1:0] from mem_read_data; LB/LH sign-extend, LBU/LHU zero-extend, LW pass; resp_valid=1; -> IDLE.
- MERGE_WRITE: mem_write_en=1; mem_write_data = mem_read_data with selected byte (addr_q[1:0]) or halfword (addr_q[1]) replaced by wdata_q[7:0]/[15:0]; resp_valid=1; -> IDLE.
- STORE_WORD: mem_write_en=1, mem_write_data=wdata_q; resp_valid=1; -> IDLE.
- ERROR_RESP: resp_valid=1, resp_error=1, resp_rdata=0; no memory enables; -> IDLE.
- Memory enables are 0 in every state not listed above; mem_write_data=0 when mem_write_en=0.
- Byte lanes little-endian: addr[1:0]=00 -> bits [7:0], 11 -> [31:24].

## Timing
- Reset: state IDLE; req_ready=1 from the cycle after reset; resp_valid, resp_error, resp_rdata, mem_read_en, mem_write_en, mem_write_data=0; mem_address=0.
- While rst=1, mem_read_en and mem_write_en forced 0 combinationally, regardless of state. Reset mid-operation abandons the request: no write issued, no response.
- Latency from accept cycle N: SW, error -> resp_valid at N+1. Loads, SB, SH -> resp_valid at N+2.
- SW write issued at N+1; SB/SH read at N+1, write at N+2.
- req_ready=0 from N+1 until the response cycle. The earliest next accept is the cycle after resp_valid. No overlap of requests.
- Outputs in non-IDLE states are decoded from registered state only; no combinational path from req_* to mem_*.

## Test plan
- Memory word 0x2000 = 0x8899AABB. LB 0x2001 -> resp_rdata 0xFFFFFFAA at N+2; LBU 0x2003 -> 0x00000088; LH 0x2002 -> 0xFFFF8899; LHU 0x2000 -> 0x0000AABB; LW 0x2000 -> 0x8899AABB.
- SB 0x2001, wdata 0x123456CC -> read at N+1, write 0x8899CCBB to 0x2000 at N+2. SH 0x2002, wdata 0x0000BEEF -> 0xBEEFAABB.
- SW 0x2004, wdata 0x12345678 -> mem_write_en at N+1 with 0x12345678, resp_valid at N+1, error 0.
- LW 0x2002, LH 0x2003, SH 0x2001, load funct3=011 -> each gets resp_valid+resp_error at N+1, rdata 0; mem_read_en/mem_write_en never asserted.
- req_valid held high across back-to-back LB then SB. Check req_ready low while busy, second accept exactly one cycle after the first resp_valid, and no dropped or duplicated request.
- Assert rst in the MERGE_WRITE cycle of SB 0x2000 -> mem_write_en=0, memory unchanged, no resp_valid. req_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/riscv_mem_access_unit.sv
// riscv_mem_access_unit
// Load/store unit between the pipeline and a word-organised synchronous
// memory port with one-cycle read latency. It takes one byte, halfword or
// word request at a time. Loads are lane-extracted and sign- or
// zero-extended. Sub-word stores are done as read-modify-write. Misaligned
// or illegal requests get an error response and never touch memory.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   req_valid / req_ready      request handshake (ready only in IDLE)
//   req_write, req_funct3      store/load select and RISC-V funct3
//   req_address, req_wdata     byte address and store data
//   resp_valid/error/rdata     one-cycle completion pulse with result
//   mem_read_en/write_en       memory strobes
//   mem_address                word-aligned address to memory
//   mem_write_data             word to write (0 when not writing)
//   mem_read_data              memory data, valid the cycle after read_en
//
// state       | meaning
// IDLE        | ready for a request
// READ        | memory read for a load or for a sub-word store
// LOAD_RESP   | extract the lane from the read data and respond
// STORE_WORD  | full-word write and respond
// MERGE_WRITE | write the read word with the new byte/halfword merged in
// ERROR_RESP  | respond with error, no memory access
module riscv_mem_access_unit #(
    parameter int PRINT_MEMORY_TRANSACTIONS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] READ        = 3'd1;
    localparam logic [2:0] LOAD_RESP   = 3'd2;
    localparam logic [2:0] STORE_WORD  = 3'd3;
    localparam logic [2:0] MERGE_WRITE = 3'd4;
    localparam logic [2:0] ERROR_RESP  = 3'd5;

    logic [2:0]  state;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        req_err;
    logic [2:0]  accept_state;

    always_comb begin
        req_err = 1'b0;
        if (req_write) begin
            case (req_funct3)
                3'b000:  req_err = 1'b0;
                3'b001:  req_err = req_address[0];
                3'b010:  req_err = (req_address[1:0] != 2'b00);
                default: req_err = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b100: req_err = 1'b0;
                3'b001, 3'b101: req_err = req_address[0];
                3'b010:         req_err = (req_address[1:0] != 2'b00);
                default:        req_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        if (req_err)
            accept_state = ERROR_RESP;
        else if (req_write && (req_funct3 == 3'b010))
            accept_state = STORE_WORD;
        else
            accept_state = READ;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state    <= accept_state;
                        write_q  <= req_write;
                        funct3_q <= req_funct3;
                        addr_q   <= req_address;
                        wdata_q  <= req_wdata;
                    end
                end
                READ:    state <= write_q ? MERGE_WRITE : LOAD_RESP;
                default: state <= IDLE;
            endcase
        end
    end

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_value;
    logic [31:0] merged_word;

    always_comb begin
        case (addr_q[1:0])
            2'b00:   sel_byte = mem_read_data[7:0];
            2'b01:   sel_byte = mem_read_data[15:8];
            2'b10:   sel_byte = mem_read_data[23:16];
            default: sel_byte = mem_read_data[31:24];
        endcase
        sel_half = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];

        case (funct3_q)
            3'b000:  load_value = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_value = {24'h0, sel_byte};
            3'b001:  load_value = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_value = {16'h0, sel_half};
            3'b010:  load_value = mem_read_data;
            default: load_value = 32'h0;
        endcase

        merged_word = mem_read_data;
        if (funct3_q[0]) begin
            if (addr_q[1]) merged_word[31:16] = wdata_q[15:0];
            else           merged_word[15:0]  = wdata_q[15:0];
        end else begin
            case (addr_q[1:0])
                2'b00:   merged_word[7:0]   = wdata_q[7:0];
                2'b01:   merged_word[15:8]  = wdata_q[7:0];
                2'b10:   merged_word[23:16] = wdata_q[7:0];
                default: merged_word[31:24] = wdata_q[7:0];
            endcase
        end
    end

    always_comb begin
        req_ready      = (state == IDLE);
        resp_valid     = 1'b0;
        resp_error     = 1'b0;
        resp_rdata     = 32'h0;
        mem_read_en    = 1'b0;
        mem_write_en   = 1'b0;
        mem_write_data = 32'h0;
        mem_address    = {addr_q[31:2], 2'b00};
        case (state)
            READ: mem_read_en = 1'b1;
            LOAD_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = load_value;
            end
            STORE_WORD: begin
                mem_write_en   = 1'b1;
                mem_write_data = wdata_q;
                resp_valid     = 1'b1;
            end
            MERGE_WRITE: begin
                mem_write_en   = 1'b1;
                mem_write_data = merged_word;
                resp_valid     = 1'b1;
            end
            ERROR_RESP: begin
                resp_valid = 1'b1;
                resp_error = 1'b1;
            end
            default: ;
        endcase
        // Reset abandons whatever is in flight this very cycle.
        if (rst) begin
            mem_read_en    = 1'b0;
            mem_write_en   = 1'b0;
            mem_write_data = 32'h0;
            resp_valid     = 1'b0;
            resp_error     = 1'b0;
            resp_rdata     = 32'h0;
        end
    end

    generate
        if (PRINT_MEMORY_TRANSACTIONS != 0) begin : g_print
            always_ff @(posedge clk) begin
                if (!rst && req_valid && req_ready)
                    $display("mau req w=%0d f3=%0d addr=%h wdata=%h",
                             req_write, req_funct3, req_address, req_wdata);
                if (resp_valid)
                    $display("mau resp err=%0d rdata=%h", resp_error, resp_rdata);
            end
        end
    endgenerate

endmodule
